// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one spi_master among NUM_REQ clients, one transfer per grant.
// Grant is combinational in IDLE; m_start follows one cycle later; rx data returns one cycle after m_done.
module spi_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_data,
  input  logic [NUM_REQ*$clog2(NUM_SLAVES)-1:0]  req_slave,
  input  logic [NUM_REQ*2-1:0]                   req_mode,
  input  logic [15:0]                            clk_div_cfg,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [DATA_WIDTH-1:0]                  rsp_data,
  output logic                                   rsp_err,
  output logic [DATA_WIDTH-1:0]                  m_tx_data,
  output logic [$clog2(NUM_SLAVES)-1:0]          m_slave_sel,
  output logic                                   m_cpol,
  output logic                                   m_cpha,
  output logic [15:0]                            m_clk_div,
  output logic                                   m_start,
  input  logic [DATA_WIDTH-1:0]                  m_rx_data,
  input  logic                                   m_done,
  input  logic                                   m_busy
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, GAP} state_e;

  state_e                 state_q;
  logic [IW-1:0]          rr_q;
  logic [WW-1:0]          wd_q;
  logic [GW-1:0]          gap_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_data_q;
  logic                   rsp_err_q;
  logic [DATA_WIDTH-1:0]  tx_data_q;
  logic [SW-1:0]          slave_sel_q;
  logic                   cpol_q;
  logic                   cpha_q;
  logic [15:0]            clk_div_q;
  logic                   start_q;

  logic                   grant_vld;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          cand_idx;
  logic                   grant_fire;

  // Search starts one past the last owner, so the previous winner ranks last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is held, since the grant is combinational.
  assign grant_fire = rst_n && (state_q == IDLE) && !m_busy && grant_vld;
  assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_idx) : '0;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign m_tx_data   = tx_data_q;
  assign m_slave_sel = slave_sel_q;
  assign m_cpol      = cpol_q;
  assign m_cpha      = cpha_q;
  assign m_clk_div   = clk_div_q;
  assign m_start     = start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= IW'(NUM_REQ - 1);
      wd_q        <= '0;
      gap_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      tx_data_q   <= '0;
      slave_sel_q <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      clk_div_q   <= '0;
      start_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            tx_data_q   <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            slave_sel_q <= req_slave[grant_idx*SW +: SW];
            {cpol_q, cpha_q} <= req_mode[grant_idx*2 +: 2];
            clk_div_q   <= clk_div_cfg;
            rr_q        <= grant_idx;
            start_q     <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          start_q <= 1'b0;
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // m_done is checked first so a completion on the cutoff cycle is not reported as a timeout.
          if (m_done) begin
            rsp_data_q  <= m_rx_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << rr_q;
            state_q     <= RESP;
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << rr_q;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          gap_q       <= GW'(GAP_CYCLES);
          state_q     <= GAP;
        end
        GAP: begin
          // An aborted master may still be busy; hold off the next grant until it lets go.
          if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
          end else if (!m_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: a behavioural spi_master stub plus an expected-response queue.
module tb_spi_txn_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 4;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [7:0]  req_slave;
  logic [7:0]  req_mode;
  logic [15:0] clk_div_cfg;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  m_tx_data;
  logic [1:0]  m_slave_sel;
  logic        m_cpol;
  logic        m_cpha;
  logic [15:0] m_clk_div;
  logic        m_start;
  logic [7:0]  m_rx_data;
  logic        m_done;
  logic        m_busy;

  logic        stub_busy;
  logic        busy_force;
  logic        stub_en;
  int          stub_delay;
  logic [7:0]  stub_xor;

  logic [45:0] outs;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int         owner;
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  assign m_busy = stub_busy | busy_force;
  assign outs = {req_ready, rsp_valid, rsp_data, rsp_err, m_tx_data, m_slave_sel,
                 m_cpol, m_cpha, m_clk_div, m_start};

  spi_txn_arbiter #(
    .NUM_REQ(NREQ), .NUM_SLAVES(4), .DATA_WIDTH(8), .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_slave(req_slave), .req_mode(req_mode), .clk_div_cfg(clk_div_cfg),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_tx_data(m_tx_data), .m_slave_sel(m_slave_sel), .m_cpol(m_cpol), .m_cpha(m_cpha),
    .m_clk_div(m_clk_div), .m_start(m_start), .m_rx_data(m_rx_data),
    .m_done(m_done), .m_busy(m_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master stub: busy from the cycle after m_start, m_done stub_delay cycles after m_start.
  initial begin
    stub_busy = 1'b0;
    m_done    = 1'b0;
    m_rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (m_start && stub_en) begin
        stub_busy = 1'b1;
        repeat (stub_delay) @(posedge clk);
        #1;
        m_done    = 1'b1;
        m_rx_data = m_tx_data ^ stub_xor;
        @(posedge clk); #1;
        m_done    = 1'b0;
        stub_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] s, input logic [1:0] m);
    req_data[i*8 +: 8]  = d;
    req_slave[i*2 +: 2] = s;
    req_mode[i*2 +: 2]  = m;
  endtask

  task automatic wait_grant(input int limit, output int g, output int at, output logic [3:0] raw, output bit ok);
    ok = 1'b0; g = -1; at = 0; raw = 4'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        ok = 1'b1; at = cyc; raw = req_ready;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) g = j;
      end
    end
  endtask

  task automatic wait_rsp(input int limit, output int at, output logic [3:0] raw, output bit ok);
    ok = 1'b0; at = 0; raw = 4'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) begin
        ok = 1'b1; at = cyc; raw = rsp_valid;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h0; req_slave = 8'h0; req_mode = 8'h0;
    clk_div_cfg = 16'h0; busy_force = 1'b0; stub_en = 1'b1; stub_delay = 20; stub_xor = 8'hFF;
    repeat (3) tick();
    n_checks++;
    if (outs !== 46'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    req_valid = 4'h0;
    tick(); rst_n = 1'b1;
    tick();
    n_checks++;
    if (outs !== 46'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", outs); end
  endtask

  task automatic test_round_robin();
    int g, gat, sat, rat, prev_rsp;
    logic [3:0] raw, exp_oh;
    logic [7:0] exp_tx;
    bit ok;
    exp_t e;
    clk_div_cfg = 16'd3; stub_delay = 20; stub_xor = 8'hFF;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * i + 1), 2'(i), 2'(i));
    req_valid = 4'hF;
    prev_rsp = 0;
    for (int n = 0; n < 12; n++) begin
      wait_grant(200, g, gat, raw, ok);
      n_checks++;
      if (!ok || g !== n % NREQ) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", n, g, n % NREQ);
      end
      if (ok) begin
        exp_tx = req_data[g*8 +: 8];
        exp_q.push_back('{owner: g, data: exp_tx ^ 8'hFF, err: 1'b0});
        @(negedge clk);
        sat = cyc;
        n_checks++;
        if (m_start !== 1'b1 || m_tx_data !== exp_tx || m_slave_sel !== 2'(g)) begin
          n_fail++; $display("FAIL rr_start[%0d]: start=%b tx=%h sel=%0d expected tx=%h sel=%0d",
                             n, m_start, m_tx_data, m_slave_sel, exp_tx, g);
        end
        if (n > 0) begin
          n_checks++;
          if (sat - prev_rsp < GAP + 2) begin
            n_fail++; $display("FAIL rr_gap[%0d]: got %0d cycles expected >= %0d", n, sat - prev_rsp, GAP + 2);
          end
        end
        // Changing the winner's fields mid-flight must not reach the master.
        req_data[g*8 +: 8] = exp_tx + 8'h40;
        if (n == 11) req_valid = 4'h0;
        wait_rsp(100, rat, raw, ok);
        prev_rsp = rat;
        e = exp_q.pop_front();
        exp_oh = 4'b0001 << e.owner;
        n_checks++;
        if (!ok || raw !== exp_oh || rsp_data !== e.data || rsp_err !== e.err) begin
          n_fail++; $display("FAIL rr_rsp[%0d]: valid=%b data=%h err=%b expected valid=%b data=%h err=%b",
                             n, raw, rsp_data, rsp_err, exp_oh, e.data, e.err);
        end
      end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_single();
    int g, gat, sat, rat, dcyc;
    logic [3:0] raw;
    bit ok;
    exp_t e;
    repeat (10) tick();
    stub_xor = 8'hA5 ^ 8'h3C; stub_delay = 20;
    set_req(1, 8'hA5, 2'd2, 2'b11); clk_div_cfg = 16'd6;
    req_valid = 4'b0010; dcyc = cyc;
    wait_grant(20, g, gat, raw, ok);
    n_checks++;
    if (!ok || raw !== 4'b0010 || gat !== dcyc) begin
      n_fail++; $display("FAIL single_grant: ready=%b cycle=%0d expected 0010 at %0d", raw, gat, dcyc);
    end
    exp_q.push_back('{owner: 1, data: 8'h3C, err: 1'b0});
    tick(); req_valid = 4'b0;
    @(negedge clk); sat = cyc;
    n_checks++;
    if (m_start !== 1'b1 || m_tx_data !== 8'hA5 || m_slave_sel !== 2'd2 || m_cpol !== 1'b1 ||
        m_cpha !== 1'b1 || m_clk_div !== 16'd6) begin
      n_fail++; $display("FAIL single_start: start=%b tx=%h sel=%0d cpol=%b cpha=%b div=%0d expected 1 a5 2 1 1 6",
                         m_start, m_tx_data, m_slave_sel, m_cpol, m_cpha, m_clk_div);
    end
    wait_rsp(100, rat, raw, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || raw !== 4'b0010 || rat !== sat + 21 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL single_rsp: valid=%b at=%0d data=%h err=%b expected 0010 at %0d data=%h err=0",
                         raw, rat, rsp_data, rsp_err, sat + 21, e.data);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0 || rsp_data !== 8'h3C || m_cpol !== 1'b1) begin
      n_fail++; $display("FAIL single_hold: valid=%b data=%h cpol=%b expected 0000 3c 1", rsp_valid, rsp_data, m_cpol);
    end
  endtask

  task automatic test_timeout();
    int g, gat, sat, rat, drop;
    logic [3:0] raw;
    bit ok;
    exp_t e;
    repeat (10) tick();
    stub_en = 1'b0;
    set_req(2, 8'h5A, 2'd1, 2'b00); set_req(0, 8'h77, 2'd0, 2'b01);
    req_valid = 4'b0100;
    wait_grant(20, g, gat, raw, ok);
    n_checks++;
    if (!ok || g !== 2) begin n_fail++; $display("FAIL to_grant: got %0d expected 2", g); end
    exp_q.push_back('{owner: 2, data: 8'h00, err: 1'b1});
    tick(); req_valid = 4'b0; busy_force = 1'b1;
    @(negedge clk); sat = cyc;
    req_valid = 4'b0001;
    wait_rsp(TO + 20, rat, raw, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || raw !== 4'b0100 || rat !== sat + TO + 1 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL to_rsp: valid=%b at=%0d data=%h err=%b expected 0100 at %0d data=00 err=1",
                         raw, rat, rsp_data, rsp_err, sat + TO + 1);
    end
    wait_grant(30, g, gat, raw, ok);
    n_checks++;
    if (ok) begin n_fail++; $display("FAIL to_busy_hold: got grant %0d expected none", g); end
    tick(); busy_force = 1'b0; drop = cyc;
    wait_grant(5, g, gat, raw, ok);
    n_checks++;
    if (!ok || g !== 0 || gat !== drop + 1) begin
      n_fail++; $display("FAIL to_release_grant: got %0d at %0d expected 0 at %0d", g, gat, drop + 1);
    end
    stub_en = 1'b1; stub_xor = 8'hFF; stub_delay = 20;
    exp_q.push_back('{owner: 0, data: 8'h88, err: 1'b0});
    tick(); req_valid = 4'b0;
    wait_rsp(100, rat, raw, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || raw !== 4'b0001 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL to_next_rsp: valid=%b data=%h err=%b expected 0001 88 0", raw, rsp_data, rsp_err);
    end
  endtask

  task automatic test_race();
    int g, gat, sat, rat;
    logic [3:0] raw;
    bit ok;
    exp_t e;
    repeat (10) tick();
    stub_delay = TO; stub_xor = 8'h0F;
    set_req(3, 8'hC3, 2'd3, 2'b10);
    req_valid = 4'b1000;
    wait_grant(20, g, gat, raw, ok);
    exp_q.push_back('{owner: 3, data: 8'hCC, err: 1'b0});
    tick(); req_valid = 4'b0;
    @(negedge clk); sat = cyc;
    wait_rsp(TO + 20, rat, raw, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || raw !== 4'b1000 || rat !== sat + TO + 1 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL race_rsp: valid=%b at=%0d data=%h err=%b expected 1000 at %0d data=cc err=0",
                         raw, rat, rsp_data, rsp_err, sat + TO + 1);
    end
  endtask

  task automatic test_busy_block();
    int g, gat, rat, drop;
    logic [3:0] raw;
    bit ok;
    exp_t e;
    repeat (10) tick();
    stub_delay = 20; stub_xor = 8'hFF;
    busy_force = 1'b1;
    set_req(3, 8'h3E, 2'd0, 2'b00);
    req_valid = 4'b1000;
    wait_grant(20, g, gat, raw, ok);
    n_checks++;
    if (ok) begin n_fail++; $display("FAIL busy_block: got grant %0d expected none", g); end
    tick(); busy_force = 1'b0; drop = cyc;
    wait_grant(5, g, gat, raw, ok);
    n_checks++;
    if (!ok || g !== 3 || gat !== drop) begin
      n_fail++; $display("FAIL busy_release_grant: got %0d at %0d expected 3 at %0d", g, gat, drop);
    end
    exp_q.push_back('{owner: 3, data: 8'hC1, err: 1'b0});
    tick(); req_valid = 4'b0;
    wait_rsp(100, rat, raw, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || raw !== 4'b1000 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL busy_rsp: valid=%b data=%h err=%b expected 1000 c1 0", raw, rsp_data, rsp_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int g, gat, rat;
    logic [3:0] raw;
    bit ok;
    exp_t e;
    repeat (10) tick();
    stub_en = 1'b0;
    set_req(1, 8'h42, 2'd1, 2'b11);
    req_valid = 4'b0010;
    wait_grant(20, g, gat, raw, ok);
    tick(); req_valid = 4'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    set_req(0, 8'h61, 2'd2, 2'b01); set_req(2, 8'h62, 2'd3, 2'b10);
    req_valid = 4'b0101;
    #1;
    n_checks++;
    if (outs !== 46'h0) begin n_fail++; $display("FAIL reset_mid_wait: got %h expected 0", outs); end
    wait_rsp(3, rat, raw, ok);
    n_checks++;
    if (ok) begin n_fail++; $display("FAIL reset_no_rsp: got rsp_valid=%b expected none", raw); end
    tick(); stub_en = 1'b1; stub_delay = 20; stub_xor = 8'hFF;
    rst_n = 1'b1;
    wait_grant(10, g, gat, raw, ok);
    n_checks++;
    if (!ok || raw !== 4'b0001) begin n_fail++; $display("FAIL reset_prio: got ready=%b expected 0001", raw); end
    exp_q.push_back('{owner: 0, data: 8'h9E, err: 1'b0});
    tick(); req_valid = 4'b0;
    wait_rsp(100, rat, raw, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || raw !== 4'b0001 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL reset_rsp: valid=%b data=%h err=%b expected 0001 9e 0", raw, rsp_data, rsp_err);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_race();
    test_busy_block();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
